// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result handshake bundle for adder_pipe; no logic, no latency.
// Both directions use valid/ready. The slave drives in_ready and result; the master drives operands and out_ready.
interface adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, X, Y, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, X, Y, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: add/sub, STAGE_BITS resolved per stage, latency WIDTH/STAGE_BITS cycles; stall freezes every stage.
// in_ready = !out_valid || out_ready; ADDER_PIPE_SAT_EN makes the final stage saturate the sum.
module adder_pipe #(
  parameter int WIDTH      = 8,
  parameter int STAGE_BITS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  adder_pipe_if.slave  bus
);

  localparam int SB     = STAGE_BITS;
  localparam int NSTAGE = WIDTH / STAGE_BITS;

  if (WIDTH < 1 || STAGE_BITS < 1 || (WIDTH % STAGE_BITS) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a positive multiple of STAGE_BITS");
  end

  logic [NSTAGE-1:0] vld_q;
  logic [NSTAGE-1:0] c_q;
  logic              sub_q [NSTAGE];
  logic [WIDTH-1:0]  a_q   [NSTAGE];
  logic [WIDTH-1:0]  b_q   [NSTAGE];
  logic [WIDTH-1:0]  s_q   [NSTAGE];

  logic [NSTAGE-1:0] vld_i;
  logic [NSTAGE-1:0] c_i;
  logic              sub_i [NSTAGE];
  logic [WIDTH-1:0]  a_i   [NSTAGE];
  logic [WIDTH-1:0]  b_i   [NSTAGE];
  logic [WIDTH-1:0]  s_i   [NSTAGE];

  logic [SB:0]       seg   [NSTAGE];
  logic [NSTAGE-1:0] c_n;
  logic [WIDTH-1:0]  s_n   [NSTAGE];
  logic [WIDTH-1:0]  s_last;
  logic              advance;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Stage 0 takes the bus; Y is pre-inverted so subtraction is X + ~Y + 1.
  always_comb begin
    vld_i[0] = bus.in_valid;
    c_i[0]   = bus.sub;
    sub_i[0] = bus.sub;
    a_i[0]   = bus.X;
    b_i[0]   = bus.sub ? ~bus.Y : bus.Y;
    s_i[0]   = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      vld_i[k] = vld_q[k-1];
      c_i[k]   = c_q[k-1];
      sub_i[k] = sub_q[k-1];
      a_i[k]   = a_q[k-1];
      b_i[k]   = b_q[k-1];
      s_i[k]   = s_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      seg[k] = {1'b0, a_i[k][k*SB +: SB]} + {1'b0, b_i[k][k*SB +: SB]}
             + {{SB{1'b0}}, c_i[k]};
      c_n[k] = seg[k][SB];
      s_n[k] = s_i[k];
      s_n[k][k*SB +: SB] = seg[k][SB-1:0];
    end
  end

`ifdef ADDER_PIPE_SAT_EN
  // Clamp only the sum; cout still reports the raw carry/borrow.
  always_comb begin
    s_last = s_n[NSTAGE-1];
    if (!sub_i[NSTAGE-1] && c_n[NSTAGE-1]) begin
      s_last = '1;
    end else if (sub_i[NSTAGE-1] && !c_n[NSTAGE-1]) begin
      s_last = '0;
    end
  end
`else
  assign s_last = s_n[NSTAGE-1];
`endif

  // Data registers load only behind a valid slot, so a bubble leaves the last result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        sub_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_i;
      for (int k = 0; k < NSTAGE; k++) begin
        if (vld_i[k]) begin
          c_q[k]   <= c_n[k];
          sub_q[k] <= sub_i[k];
          a_q[k]   <= a_i[k];
          b_q[k]   <= b_i[k];
          s_q[k]   <= (k == NSTAGE - 1) ? s_last : s_n[k];
        end
      end
    end
  end

  assign bus.out_valid = vld_q[NSTAGE-1];
  assign bus.sum       = s_q[NSTAGE-1];
  assign bus.cout      = c_q[NSTAGE-1];

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; SHALL be >= 1.
REQ-002 Parameter STAGE_BITS, default 2, bits resolved per pipeline stage; WIDTH SHALL be an integer multiple of STAGE_BITS (elaboration error otherwise).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  operand set X/Y/sub present.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port X  input  WIDTH  operand A, unsigned.
REQ-008 Port Y  input  WIDTH  operand B, unsigned.
REQ-009 Port sub  input  1  0 = X+Y, 1 = X-Y.
REQ-010 Port out_valid  output  1  result on sum/cout is valid.
REQ-011 Port out_ready  input  1  consumer takes result this cycle.
REQ-012 Port sum  output  WIDTH  result.
REQ-013 Port cout  output  1  add: carry out; sub: 1 = no borrow (X >= Y), 0 = borrow.

Function
REQ-014 Pipeline SHALL have NSTAGE = WIDTH/STAGE_BITS registered stages; stage k SHALL resolve bits [k*STAGE_BITS +: STAGE_BITS] using the carry registered from stage k-1 (ripple-carry across stages); higher operand bits and lower result bits SHALL be carried forward in stage registers.
REQ-015 Subtraction SHALL be computed as X + ~Y + 1 (carry-in = sub at stage 0); addition uses carry-in 0.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL be the carry out of bit WIDTH-1.
REQ-017 Handshake: transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
REQ-018 advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependency on in_valid).
REQ-019 When advance = 1 every stage SHALL shift one position; a stage with no valid data SHALL carry a bubble (valid bit 0). When advance = 0 all stage registers SHALL hold.
REQ-020 Latency: with out_ready held 1, an operand accepted on edge N SHALL appear with out_valid = 1 after edge N+NSTAGE-1... precisely: out_valid asserted in the cycle following NSTAGE rising edges after acceptance (NSTAGE cycles latency).
REQ-021 Throughput SHALL be one operation per cycle with no backpressure; results SHALL emerge in acceptance order with no loss or duplication.
REQ-022 sum/cout SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-023 in_valid = 0 with advance = 1 SHALL insert a bubble; X/Y/sub are ignored when no input transfer occurs.
REQ-024 With NSTAGE = 1 the block SHALL behave as a single registered adder with the same handshake.

Reset
REQ-025 rst_n = 0 SHALL asynchronously clear all stage valid bits, out_valid = 0, sum = 0, cout = 0; in_ready = 1 while rst_n = 0 held (out_valid = 0).
REQ-026 Reset mid-operation SHALL discard all in-flight operations; first result after release comes only from operands accepted after release.
REQ-027 Deassertion of rst_n SHALL be taken synchronously to clk by the integrating design; block needs no internal synchroniser.

Configuration
REQ-028 Macro ADDER_PIPE_SAT_EN: when defined, the final stage SHALL saturate: add with cout = 1 -> sum = all ones; sub with cout = 0 -> sum = 0; cout still reports the raw carry/borrow.
REQ-029 When ADDER_PIPE_SAT_EN is undefined, sum SHALL be the wrapped modulo result; no other behaviour differs, latency identical in both builds.

Verification (WIDTH=8, STAGE_BITS=2, NSTAGE=4 unless stated)
REQ-030 X=0x03, Y=0x05, sub=0, out_ready=1 -> sum=0x08, cout=0, out_valid exactly 4 cycles after accept.
REQ-031 X=0xFF, Y=0x01, sub=0 -> sum=0x00, cout=1 (no macro); sum=0xFF, cout=1 (ADDER_PIPE_SAT_EN).
REQ-032 X=0x05, Y=0x07, sub=1 -> sum=0xFE, cout=0 (no macro); sum=0x00, cout=0 (macro); X=0x07, Y=0x05, sub=1 -> sum=0x02, cout=1.
REQ-033 Stream 6 ops back-to-back, out_ready=0 from cycle of first out_valid for 3 cycles -> in_ready=0 during stall, sum stable, all 6 results delivered in order once out_ready=1.
REQ-034 Accept 3 ops, pull rst_n low mid-flight for 1 cycle -> out_valid=0, sum=0 immediately; no stale result after release.
REQ-035 WIDTH=3, STAGE_BITS=1: X=7, Y=7, sub=0 -> sum=6, cout=1 after 3 cycles; X=2, Y=3 -> sum=5, cout=0.
